// File: rtl/twos_to_bcd_if.sv
// Handshake and result bus between the adder datapath, the BCD converter
// and the display multiplexer.
interface twos_to_bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  ovf_in;
  logic                  busy;
  logic                  done;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd;
  logic                  err;

  modport master (
    output start, value, ovf_in,
    input  busy, done, sign, bcd, err
  );

  modport slave (
    input  start, value, ovf_in,
    output busy, done, sign, bcd, err
  );
endinterface

// File: rtl/twos_to_bcd.sv
// Sequential two's-complement to sign + BCD magnitude converter using a
// one-bit-per-clock shift-add-3 engine with start/busy/done handshake.
module twos_to_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  twos_to_bcd_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // Unsigned magnitude; the most negative input maps onto itself (2^(WIDTH-1)).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = d[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_mag;
  logic [WIDTH-1:0]  w_mag_nxt;
  logic [BW-1:0]     r_scratch;
  logic [BW-1:0]     w_scratch_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              r_sign_int;
  logic              w_sign_int_nxt;
  logic              r_ovf_int;
  logic              w_ovf_int_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_sign;
  logic              w_sign_nxt;
  logic [BW-1:0]     r_bcd;
  logic [BW-1:0]     w_bcd_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic [BW+WIDTH-1:0] w_shift;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mag      <= {WIDTH{1'b0}};
      r_scratch  <= {BW{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_sign_int <= 1'b0;
      r_ovf_int  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sign     <= 1'b0;
      r_bcd      <= {BW{1'b0}};
      r_err      <= 1'b0;
    end else begin
      r_mag      <= w_mag_nxt;
      r_scratch  <= w_scratch_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sign_int <= w_sign_int_nxt;
      r_ovf_int  <= w_ovf_int_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_sign     <= w_sign_nxt;
      r_bcd      <= w_bcd_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Next-state and next-register logic; outputs hold unless a FINISH step updates them.
  always_comb begin
    w_state_nxt    = r_state;
    w_mag_nxt      = r_mag;
    w_scratch_nxt  = r_scratch;
    w_cnt_nxt      = r_cnt;
    w_sign_int_nxt = r_sign_int;
    w_ovf_int_nxt  = r_ovf_int;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_sign_nxt     = r_sign;
    w_bcd_nxt      = r_bcd;
    w_err_nxt      = r_err;
    w_shift        = {add3_digits(r_scratch), r_mag} << 1;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt    = S_CONV;
          w_sign_int_nxt = bus.value[WIDTH-1];
          w_mag_nxt      = magnitude(bus.value);
          w_ovf_int_nxt  = bus.ovf_in;
          w_scratch_nxt  = {BW{1'b0}};
          w_cnt_nxt      = {CW{1'b0}};
          w_busy_nxt     = 1'b1;
        end else begin
          w_busy_nxt     = 1'b0;
        end
      end
      S_CONV: begin
        w_scratch_nxt = w_shift[BW+WIDTH-1:WIDTH];
        w_mag_nxt     = w_shift[WIDTH-1:0];
        w_cnt_nxt     = r_cnt + CW'(1);
        w_busy_nxt    = 1'b1;
        // Last shift happens when the counter reaches WIDTH-1 before the step.
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_state_nxt = S_CONV;
        end
      end
      S_FINISH: begin
        w_bcd_nxt   = r_scratch;
        w_sign_nxt  = r_sign_int;
        w_err_nxt   = r_ovf_int;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sign = r_sign;
  assign bus.bcd  = r_bcd;
  assign bus.err  = r_err;

endmodule
